// File: rtl/ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// ram_arb_pkg
// Shared definitions for the two-requester RAM command arbiter:
//   - command/data widths
//   - command opcodes carried in bits [9:8] of a command word
//   - arbiter FSM state encoding
// ---------------------------------------------------------------------------
package ram_arb_pkg;

    localparam int CMD_W  = 10;   // [9:8] opcode, [7:0] payload
    localparam int DATA_W = 8;    // memory read-data width

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOCKED_WR = 2'd1,
        LOCKED_RD = 2'd2,
        WAIT_RD   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/arb_timeout_counter.sv
// ---------------------------------------------------------------------------
// arb_timeout_counter
// Counts cycles spent in a lock state and flags the last allowed cycle.
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   i_clear   in   restart the count (asserted on every state change)
//   i_enable  in   count this cycle (a lock is being held)
//   o_expire  out  this is the LOCK_TIMEOUT-th consecutive enabled cycle
// ---------------------------------------------------------------------------
module arb_timeout_counter #(
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LOCK_TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LAST)) begin
            // Saturate: the owner leaves the lock on expiry, so wrapping is never needed.
            r_count <= r_count + 1'b1;
        end
    end

    // The counter reads 0 in the first cycle of a state, so LAST marks the
    // LOCK_TIMEOUT-th cycle held.
    assign o_expire = i_enable && (r_count == LAST);

endmodule

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
// Arbitrates two command requesters onto one memory command port. A write
// (addr then data) or read (addr then data, then wait for memory data) locks
// the port to one requester until it completes, misbehaves for too long, or
// reset intervenes.
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   r0/r1_valid    in   requester command valid
//   r0/r1_data     in   command word, [9:8] opcode, [7:0] payload
//   r0/r1_ready    out  command accepted when valid && ready
//   r0/r1_rsp_*    out  one-cycle read-data pulse and its data
//   r0/r1_err      out  one-cycle protocol / timeout error pulse
//   ram_din        out  command to memory
//   ram_rx_valid   out  command strobe to memory
//   ram_dout       in   memory read data
//   ram_tx_valid   in   memory read-data strobe
//   owner          out  one-hot lock holder, 00 when idle
// ---------------------------------------------------------------------------
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_valid,
    input  logic [CMD_W-1:0]  r0_data,
    output logic              r0_ready,
    output logic              r0_rsp_valid,
    output logic [DATA_W-1:0] r0_rsp_data,
    output logic              r0_err,
    input  logic              r1_valid,
    input  logic [CMD_W-1:0]  r1_data,
    output logic              r1_ready,
    output logic              r1_rsp_valid,
    output logic [DATA_W-1:0] r1_rsp_data,
    output logic              r1_err,
    output logic [CMD_W-1:0]  ram_din,
    output logic              ram_rx_valid,
    input  logic [DATA_W-1:0] ram_dout,
    input  logic              ram_tx_valid,
    output logic [1:0]        owner
);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    logic [1:0]        r_owner;
    logic              r_prio_r1;      // 1: r1 wins the next tie
    logic [CMD_W-1:0]  r_ram_din;
    logic              r_ram_rx_valid;
    logic [1:0]        r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic [1:0]        r_err;

    logic [1:0]        w_valid;
    logic [1:0]        w_ready;
    logic [1:0]        w_accept;
    logic              w_any_accept;
    logic [CMD_W-1:0]  w_cmd;
    logic [1:0]        w_op;
    logic              w_fwd;
    logic [1:0]        w_err;
    logic [1:0]        w_rsp;
    logic              w_expire;
    logic              w_timer_clear;
    logic              w_timer_enable;

    assign w_valid      = {r1_valid, r0_valid};
    assign w_accept     = w_valid & w_ready;
    assign w_any_accept = |w_accept;
    // At most one requester is ready, so the accepted word is unambiguous.
    assign w_cmd        = w_accept[1] ? r1_data : r0_data;
    assign w_op         = w_cmd[CMD_W-1 -: 2];

    // Ready: in IDLE only the arbitration winner among valid requesters,
    // in a lock only the owner, never while waiting for read data.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_ready = 2'b00;
        if (!rst) begin
            unique case (r_state)
                IDLE: begin
                    if (r0_valid && (!r1_valid || !r_prio_r1)) begin
                        w_ready = 2'b01;
                    end else if (r1_valid) begin
                        w_ready = 2'b10;
                    end
                end
                LOCKED_WR, LOCKED_RD: w_ready = r_owner;
                default:              w_ready = 2'b00;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_fwd        = 1'b0;
        w_err        = 2'b00;
        w_rsp        = 2'b00;
        unique case (r_state)
            IDLE: begin
                if (w_any_accept) begin
                    if (w_op == OP_WR_ADDR) begin
                        w_fwd        = 1'b1;
                        w_state_next = LOCKED_WR;
                    end else if (w_op == OP_RD_ADDR) begin
                        w_fwd        = 1'b1;
                        w_state_next = LOCKED_RD;
                    end else begin
                        // Data phase with no address phase: drop it.
                        w_err = w_accept;
                    end
                end
            end
            LOCKED_WR, LOCKED_RD: begin
                if (w_any_accept &&
                    (w_op == ((r_state == LOCKED_WR) ? OP_WR_DATA : OP_RD_DATA))) begin
                    w_fwd        = 1'b1;
                    w_state_next = (r_state == LOCKED_WR) ? IDLE : WAIT_RD;
                end else begin
                    // A wrong opcode and an expiry in the same cycle share one pulse.
                    if (w_any_accept || w_expire) begin
                        w_err = r_owner;
                    end
                    if (w_expire) begin
                        w_state_next = IDLE;
                    end
                end
            end
            WAIT_RD: begin
                if (ram_tx_valid) begin
                    w_rsp        = r_owner;
                    w_state_next = IDLE;
                end else if (w_expire) begin
                    w_err        = r_owner;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Any state change restarts the timer; only lock states let it run.
    assign w_timer_clear  = (w_state_next != r_state);
    assign w_timer_enable = (r_state != IDLE);

    arb_timeout_counter #(
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_timer_clear),
        .i_enable (w_timer_enable),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_owner        <= 2'b00;
            r_prio_r1      <= 1'b0;
            r_ram_din      <= '0;
            r_ram_rx_valid <= 1'b0;
            r_rsp_valid    <= 2'b00;
            r_rsp_data     <= '0;
            r_err          <= 2'b00;
        end else begin
            r_state        <= w_state_next;
            r_ram_rx_valid <= w_fwd;
            r_rsp_valid    <= w_rsp;
            r_err          <= w_err;
            if (w_fwd) begin
                r_ram_din <= w_cmd;
            end
            if (|w_rsp) begin
                r_rsp_data <= ram_dout;
            end
            // Pointer moves on every IDLE grant, including dropped commands.
            if ((r_state == IDLE) && w_any_accept) begin
                r_prio_r1 <= w_accept[0];
            end
            if (w_state_next == IDLE) begin
                r_owner <= 2'b00;
            end else if (r_state == IDLE) begin
                r_owner <= w_accept;
            end
        end
    end

    assign r0_ready     = w_ready[0];
    assign r1_ready     = w_ready[1];
    assign r0_rsp_valid = r_rsp_valid[0];
    assign r1_rsp_valid = r_rsp_valid[1];
    assign r0_rsp_data  = r_rsp_data;
    assign r1_rsp_data  = r_rsp_data;
    assign r0_err       = r_err[0];
    assign r1_err       = r_err[1];
    assign ram_din      = r_ram_din;
    assign ram_rx_valid = r_ram_rx_valid;
    assign owner        = r_owner;

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
// Drives both requesters and the memory read-data port with directed
// scenarios followed by random traffic. A transaction-level reference model
// decides each cycle which requester should be accepted and what the arbiter
// must emit one cycle later; those expectations go into a time-stamped queue
// that an independent monitor drains whenever the DUT strobes an output.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       r0_valid, r1_valid;
    logic [9:0] r0_data, r1_data;
    logic       r0_ready, r1_ready;
    logic       r0_rsp_valid, r1_rsp_valid;
    logic [7:0] r0_rsp_data, r1_rsp_data;
    logic       r0_err, r1_err;
    logic [9:0] ram_din;
    logic       ram_rx_valid;
    logic [7:0] ram_dout;
    logic       ram_tx_valid;
    logic [1:0] owner;

    always #5 clk = ~clk;

    ram_arbiter #(.LOCK_TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .r0_valid     (r0_valid),
        .r0_data      (r0_data),
        .r0_ready     (r0_ready),
        .r0_rsp_valid (r0_rsp_valid),
        .r0_rsp_data  (r0_rsp_data),
        .r0_err       (r0_err),
        .r1_valid     (r1_valid),
        .r1_data      (r1_data),
        .r1_ready     (r1_ready),
        .r1_rsp_valid (r1_rsp_valid),
        .r1_rsp_data  (r1_rsp_data),
        .r1_err       (r1_err),
        .ram_din      (ram_din),
        .ram_rx_valid (ram_rx_valid),
        .ram_dout     (ram_dout),
        .ram_tx_valid (ram_tx_valid),
        .owner        (owner)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit started = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- expected-event scoreboard ----------------
    typedef enum int {EV_RAM = 0, EV_ERR0 = 1, EV_ERR1 = 2, EV_RSP0 = 3, EV_RSP1 = 4} ev_kind_t;
    typedef struct {
        int         e_cyc;
        ev_kind_t   kind;
        logic [9:0] data;
    } ev_t;

    ev_t   q_exp[$];
    string kind_name[5] = '{"ram_cmd", "r0_err", "r1_err", "r0_rsp", "r1_rsp"};

    function automatic void expect_ev(input ev_kind_t k, input logic [9:0] d);
        ev_t e;
        e.e_cyc = cyc + 1;
        e.kind  = k;
        e.data  = d;
        q_exp.push_back(e);
    endfunction

    function automatic ev_kind_t err_of(input int who);
        return (who == 0) ? EV_ERR0 : EV_ERR1;
    endfunction

    function automatic ev_kind_t rsp_of(input int who);
        return (who == 0) ? EV_RSP0 : EV_RSP1;
    endfunction

    // ---------------- reference model ----------------
    // The port is either free, held for a write, held for a read, or awaiting
    // memory data; m_age counts cycles the current hold has lasted.
    typedef enum int {M_FREE, M_WRITE, M_READ, M_AWAIT} m_phase_t;

    m_phase_t m_phase     = M_FREE;
    int       m_holder    = 0;
    int       m_age       = 0;
    int       m_next_pick = 0;   // who wins when both ask at once
    bit       m_was_rst   = 1'b0;

    task automatic model_step();
        bit         v[2];
        logic [9:0] d[2];
        bit         want[2];
        int         k;
        logic [1:0] need;

        v[0] = r0_valid;  d[0] = r0_data;
        v[1] = r1_valid;  d[1] = r1_data;
        want[0] = 1'b0;   want[1] = 1'b0;

        if (rst) begin
            check("r0_ready_in_rst", r0_ready, 0);
            check("r1_ready_in_rst", r1_ready, 0);
            m_phase     = M_FREE;
            m_age       = 0;
            m_next_pick = 0;
            m_was_rst   = 1'b1;
            started     = 1'b1;
            return;
        end

        if (m_was_rst) begin
            check("ram_din_after_rst", ram_din, 0);
            check("rsp_data_after_rst", {r1_rsp_data, r0_rsp_data}, 0);
            m_was_rst = 1'b0;
        end

        check("owner", owner, (m_phase == M_FREE) ? 2'b00 : 2'(1 << m_holder));

        case (m_phase)
            M_FREE: begin
                if (v[0] && v[1]) want[m_next_pick] = 1'b1;
                else if (v[0])    want[0] = 1'b1;
                else if (v[1])    want[1] = 1'b1;
            end
            M_WRITE, M_READ: want[m_holder] = 1'b1;
            default: ;
        endcase
        check("r0_ready", r0_ready, want[0]);
        check("r1_ready", r1_ready, want[1]);

        k = -1;
        for (int i = 0; i < 2; i++) if (want[i] && v[i]) k = i;

        if (m_phase != M_FREE) m_age++;

        case (m_phase)
            M_FREE: begin
                if (k >= 0) begin
                    m_next_pick = 1 - k;
                    if (d[k][9:8] == OP_WR_ADDR || d[k][9:8] == OP_RD_ADDR) begin
                        expect_ev(EV_RAM, d[k]);
                        m_phase  = (d[k][9:8] == OP_WR_ADDR) ? M_WRITE : M_READ;
                        m_holder = k;
                        m_age    = 0;
                    end else begin
                        expect_ev(err_of(k), 10'h000);
                    end
                end
            end
            M_WRITE, M_READ: begin
                need = (m_phase == M_WRITE) ? OP_WR_DATA : OP_RD_DATA;
                if (k >= 0 && d[k][9:8] == need) begin
                    expect_ev(EV_RAM, d[k]);
                    m_phase = (m_phase == M_WRITE) ? M_FREE : M_AWAIT;
                    m_age   = 0;
                end else if (k >= 0 || m_age == TIMEOUT) begin
                    expect_ev(err_of(m_holder), 10'h000);
                    if (m_age == TIMEOUT) m_phase = M_FREE;
                end
            end
            M_AWAIT: begin
                if (ram_tx_valid) begin
                    expect_ev(rsp_of(m_holder), {2'b00, ram_dout});
                    m_phase = M_FREE;
                end else if (m_age == TIMEOUT) begin
                    expect_ev(err_of(m_holder), 10'h000);
                    m_phase = M_FREE;
                end
            end
            default: ;
        endcase
    endtask

    always @(negedge clk) model_step();

    // ---------------- monitor ----------------
    initial begin : monitor
        bit         hit[5];
        bit         seen[5];
        logic [9:0] got[5];
        ev_t        e;
        forever begin
            @(posedge clk);
            #3;
            if (started) begin
                hit[0] = (ram_rx_valid === 1'b1);  got[0] = ram_din;
                hit[1] = (r0_err === 1'b1);        got[1] = 10'h000;
                hit[2] = (r1_err === 1'b1);        got[2] = 10'h000;
                hit[3] = (r0_rsp_valid === 1'b1);  got[3] = {2'b00, r0_rsp_data};
                hit[4] = (r1_rsp_valid === 1'b1);  got[4] = {2'b00, r1_rsp_data};
                for (int i = 0; i < 5; i++) seen[i] = 1'b0;
                while (q_exp.size() > 0 && q_exp[0].e_cyc <= cyc) begin
                    e = q_exp.pop_front();
                    if (e.e_cyc < cyc) begin
                        check({kind_name[int'(e.kind)], "_cycle"}, e.e_cyc, cyc);
                    end else begin
                        seen[int'(e.kind)] = 1'b1;
                        if (hit[int'(e.kind)] && (e.kind == EV_RAM || e.kind == EV_RSP0 || e.kind == EV_RSP1))
                            check({kind_name[int'(e.kind)], "_data"}, got[int'(e.kind)], e.data);
                    end
                end
                for (int i = 0; i < 5; i++) check({kind_name[i], "_strobe"}, hit[i], seen[i]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit rs, input bit v0, input logic [9:0] d0,
                        input bit v1, input logic [9:0] d1,
                        input bit tx, input logic [7:0] dout);
        rst          = rs;
        r0_valid     = v0;  r0_data = d0;
        r1_valid     = v1;  r1_data = d1;
        ram_tx_valid = tx;  ram_dout = dout;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 10'h000, 0, 10'h000, 0, 8'h00);
    endtask

    task automatic do_reset();
        step(1, 0, 10'h000, 0, 10'h000, 0, 8'h00);
        step(1, 0, 10'h000, 0, 10'h000, 0, 8'h00);
    endtask

    initial begin
        do_reset();
        idle(1);

        // Write: address then data, lock released afterwards.
        step(0, 1, 10'h0A5, 0, 10'h000, 0, 8'h00);
        step(0, 1, 10'h13C, 0, 10'h000, 0, 8'h00);
        idle(3);

        // Simultaneous read requests straight after reset: r0 first, r1 after.
        do_reset();
        step(0, 1, 10'h210, 1, 10'h220, 0, 8'h00);
        step(0, 1, 10'h310, 1, 10'h220, 0, 8'h00);
        step(0, 0, 10'h000, 1, 10'h220, 0, 8'h00);
        step(0, 0, 10'h000, 1, 10'h220, 1, 8'h77);
        step(0, 0, 10'h000, 1, 10'h220, 0, 8'h00);
        step(0, 0, 10'h000, 1, 10'h320, 0, 8'h00);
        step(0, 0, 10'h000, 0, 10'h000, 1, 8'hC3);
        idle(3);

        // r1 read, memory answers while the rd-data command is on the port.
        do_reset();
        step(0, 0, 10'h000, 1, 10'h207, 0, 8'h00);
        step(0, 0, 10'h000, 1, 10'h300, 0, 8'h00);
        step(0, 0, 10'h000, 0, 10'h000, 1, 8'h5A);
        idle(3);

        // Data phase from IDLE is dropped with an error; stray memory data ignored.
        step(0, 1, 10'h100, 0, 10'h000, 1, 8'hEE);
        idle(3);

        // Abandoned write lock times out, then the waiting r1 gets the port.
        do_reset();
        step(0, 1, 10'h011, 0, 10'h000, 0, 8'h00);
        for (int i = 0; i < TIMEOUT + 1; i++) step(0, 0, 10'h000, 1, 10'h044, 0, 8'h00);
        step(0, 0, 10'h000, 1, 10'h1EE, 0, 8'h00);
        idle(3);

        // Reset during WAIT_RD: the late memory data must vanish.
        do_reset();
        step(0, 1, 10'h2AA, 0, 10'h000, 0, 8'h00);
        step(0, 1, 10'h3BB, 0, 10'h000, 0, 8'h00);
        step(0, 0, 10'h000, 0, 10'h000, 0, 8'h00);
        step(1, 0, 10'h000, 0, 10'h000, 1, 8'h99);
        step(0, 0, 10'h000, 0, 10'h000, 1, 8'h99);
        idle(3);

        // Random traffic, including occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0,
                 1'($urandom_range(0, 1)), 10'($urandom),
                 1'($urandom_range(0, 1)), 10'($urandom),
                 $urandom_range(0, 4) == 0, 8'($urandom));
        end
        idle(4);

        check("scoreboard_drained", q_exp.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter LOCK_TIMEOUT, default 16, meaning max cycles a lock (LOCKED or WAIT_RD) persists without progress.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 r0_valid / r1_valid  input  1  requester command valid.
REQ-005 r0_data / r1_data  input  10  command word; [9:8] opcode (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), [7:0] payload.
REQ-006 r0_ready / r1_ready  output  1  command accepted when valid&&ready.
REQ-007 r0_rsp_valid / r1_rsp_valid  output  1  one-cycle read-data pulse.
REQ-008 r0_rsp_data / r1_rsp_data  output  8  read data, valid with rsp_valid.
REQ-009 r0_err / r1_err  output  1  one-cycle protocol/timeout error pulse.
REQ-010 ram_din  output  10  command to memory.
REQ-011 ram_rx_valid  output  1  command strobe to memory.
REQ-012 ram_dout  input  8  memory read data.
REQ-013 ram_tx_valid  input  1  memory read-data strobe.
REQ-014 owner  output  2  one-hot current lock holder, 00 when IDLE.

Function
REQ-015 FSM states: IDLE, LOCKED_WR, LOCKED_RD, WAIT_RD.
REQ-016 IDLE: ready is combinational to the granted requester only; single requester is granted; both valid -> grant the one not granted last (round-robin pointer, r0 first after reset).
REQ-017 Accepted command at cycle t appears on ram_din with ram_rx_valid=1 at t+1; ram_rx_valid is 0 in all other cycles.
REQ-018 IDLE, accepted opcode 00 -> forwarded, LOCKED_WR, owner set; opcode 10 -> forwarded, LOCKED_RD.
REQ-019 IDLE, accepted opcode 01 or 11 -> dropped (no ram_rx_valid), err pulse to that requester at t+1, stay IDLE, pointer updated.
REQ-020 LOCKED_*: only owner ready; non-owner ready=0 regardless of valid.
REQ-021 LOCKED_WR, owner opcode 01 -> forwarded, IDLE; LOCKED_RD, owner opcode 11 -> forwarded, WAIT_RD.
REQ-022 LOCKED_*, owner any other opcode -> accepted, dropped, err pulse, lock and timer unchanged.
REQ-023 WAIT_RD: no requester ready; ram_tx_valid at cycle t -> owner rsp_valid=1, rsp_data=ram_dout at t+1, IDLE at t+1.
REQ-024 ram_tx_valid outside WAIT_RD is ignored.
REQ-025 Timer clears on every state entry; LOCKED_* or WAIT_RD held LOCK_TIMEOUT cycles -> owner err pulse, IDLE, nothing sent to memory.
REQ-026 Round-robin pointer updates only on IDLE grants.
REQ-027 Completion (IDLE entry) and new grant never in the same cycle; earliest next grant is the cycle after IDLE entry.

Reset
REQ-028 rst at clock edge -> IDLE, owner=00, pointer favors r0, timer=0, all ready/rsp_valid/err/ram_rx_valid=0, ram_din=0, rsp_data=0.
REQ-029 rst mid-lock or mid-WAIT_RD aborts silently: no err, no rsp, no ram strobe.

Structure
REQ-030 Package ram_arb_pkg holds opcode constants (OP_WR_ADDR, OP_WR_DATA, OP_RD_ADDR, OP_RD_DATA) and the state enum.
REQ-031 One sub-module arb_timeout_counter (clear, enable, LOCK_TIMEOUT parameter, expire output).

Verification
REQ-032 r0 sends 0x0A5 then 0x13C -> ram_din 0x0A5 then 0x13C, one-cycle strobes, owner back to 00, no err.
REQ-033 r0 and r1 both send opcode 10 at same cycle after reset -> r0 granted, r1_ready=0 until r0 read completes, r1 granted next.
REQ-034 r1 sends 0x207 then 0x300, memory returns ram_dout=0x5A one cycle later -> r1_rsp_valid pulse with 0x5A, r0_rsp_valid stays 0.
REQ-035 r0 sends 0x100 from IDLE -> no ram_rx_valid, r0_err pulse, state IDLE.
REQ-036 r0 sends 0x011 and goes silent -> after 16 cycles r0_err pulse, owner 00, r1 granted next cycle.
REQ-037 rst asserted during WAIT_RD, then ram_tx_valid -> no rsp_valid, all outputs at reset values.
